// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the Avalon-MM RAM slave and its wait-state LFSR.
package avalon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [7:0]  LFSR_SEED  = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from state bits 7, 5, 4, 3
  localparam logic [7:0]  LFSR_TAPS  = 8'hB8;
  localparam int unsigned WAIT_CNT_W = 4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avalon_ram_slave_lfsr8.sv
// 8-bit Fibonacci LFSR (module lfsr8) supplying random wait counts; advances when enabled.
module lfsr8
  import avalon_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= LFSR_SEED;
    end else if (i_en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/avalon_ram_slave.sv
// Avalon-MM word RAM slave with fixed (or, with AVALON_RAM_RANDOM_WAIT_EN, LFSR-random) wait states,
// byte-lane writes, address window decode and a sticky protocol/decode error flag.
module avalon_ram_slave
  import avalon_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]           r_mem [DEPTH_WORDS];
  state_t                r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [31:0]           r_readdata;
  logic                  r_err;

  logic                  w_req;
  logic                  w_is_rd;
  logic [29:0]           w_word_off;
  logic                  w_in_win;
  logic [AW-1:0]         w_idx;
  logic                  w_bad;
  logic [31:0]           w_rd_word;
  logic [WAIT_CNT_W-1:0] w_wait_cnt;

  assign w_req      = read | write;
  assign w_is_rd    = read & ~write;
  assign w_word_off = address[31:2] - BASE_ADDR[31:2];
  assign w_in_win   = (w_word_off < 30'(DEPTH_WORDS));
  assign w_idx      = w_word_off[AW-1:0];
  assign w_bad      = ~w_in_win | (address[1:0] != 2'b00) | (read & write);
  assign w_rd_word  = w_in_win ? r_mem[w_idx] : 32'h0;

`ifdef AVALON_RAM_RANDOM_WAIT_EN
  logic [7:0] w_lfsr;

  lfsr8 u_lfsr8 (
    .clk     (clk),
    .reset   (reset),
    .i_en    ((r_state == ACK) && w_req),
    .o_state (w_lfsr)
  );

  assign w_wait_cnt = WAIT_CNT_W'({1'b0, w_lfsr[2:0]});
`else
  assign w_wait_cnt = WAIT_CNT_W'(WAIT_CYCLES);
`endif

  // Stall every request until ACK; during reset any request stalls.
  assign waitrequest = w_req & ~((r_state == ACK) & reset);
  assign readdata    = r_readdata;
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_readdata <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_wait_cnt == '0) begin
              r_state <= ACK;
              if (w_is_rd) r_readdata <= w_rd_word;
            end else begin
              r_state <= WAIT;
              r_cnt   <= w_wait_cnt - WAIT_CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (!w_req) begin
            // Master withdrew before acceptance: protocol error, nothing written.
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state <= ACK;
            if (w_is_rd) r_readdata <= w_rd_word;
          end else begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
          end
        end
        ACK: begin
          r_state <= IDLE;
          if (w_req && w_bad) r_err <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte-lane write commits on the acceptance edge, in-window only.
  always_ff @(posedge clk) begin
    if (reset && (r_state == ACK) && write && w_in_win) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) r_mem[w_idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

endmodule
